fpga_robots_game_ps2_rx: RTL and testbench
==========================================

FPGA_ROBOTS_GAME_PS2_RX -- requirements
Module: fpga_robots_game_ps2_rx

Interface
REQ-001 Parameter: FILTER_LEN, 8, consecutive clk cycles the synchronized ps2_clk must hold a new level before the filtered clock changes (range 2-255).
REQ-002 Parameter: TIMEOUT, 100000, idle clk cycles between filtered falling edges mid-frame before the frame is aborted (2 ms at 50 MHz).
REQ-003 Port: clk  input  1  system clock; rising edge active; all logic synchronous to it.
REQ-004 Port: rst  input  1  reset; asynchronous, active-low.
REQ-005 Port: ps2_clk  input  1  raw PS/2 clock pin, asynchronous to clk.
REQ-006 Port: ps2_dat  input  1  raw PS/2 data pin, asynchronous to clk.
REQ-007 Port: ps2_rx_dat  output  8  last successfully received byte; feeds the control block's ps2_rx_dat.
REQ-008 Port: ps2_rx_stb  output  1  one-cycle pulse when ps2_rx_dat is new and valid.
REQ-009 Port: ps2_rx_err  output  1  one-cycle pulse on any discarded frame.
REQ-010 Port: dbg  output  1  high while the state machine is not IDLE.

Function
REQ-011 ps2_clk and ps2_dat SHALL each pass through a 2-flop synchronizer before any other use.
REQ-012 Filtered clock SHALL change only after the synchronized ps2_clk has held the opposite level for FILTER_LEN consecutive cycles; shorter pulses have no effect.
REQ-013 A falling edge SHALL be detected in the single cycle the filtered clock goes 1->0; the synchronized ps2_dat is sampled in that same cycle.
REQ-014 States: IDLE, DATA, PARITY, STOP; frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-015 IDLE: edge with sample 0 -> DATA, bit counter 0; edge with sample 1 -> stay IDLE, pulse ps2_rx_err.
REQ-016 DATA: each edge shifts the sample into bit [counter] of the shift register; after the 8th bit -> PARITY.
REQ-017 PARITY: the edge stores the parity sample -> STOP.
REQ-018 STOP: on the edge, a sample of 1 with valid parity (REQ-029) SHALL load ps2_rx_dat and pulse ps2_rx_stb; otherwise pulse ps2_rx_err. Both cases -> IDLE.
REQ-019 ps2_rx_stb/ps2_rx_err SHALL be high for exactly the one clk cycle after the STOP-edge cycle; the two SHALL never be high together.
REQ-020 ps2_rx_dat SHALL change only alongside ps2_rx_stb and hold until the next valid frame.
REQ-021 Timeout counter SHALL reset on every detected edge and count while not IDLE; reaching TIMEOUT -> IDLE with one ps2_rx_err pulse, partial byte discarded, ps2_rx_dat unchanged.
REQ-022 An edge in the same cycle the timeout is reached SHALL take priority; the frame continues.
REQ-023 The timeout counter SHALL saturate and SHALL NOT wrap; its width is sized from TIMEOUT.
REQ-024 Back-to-back frames with no idle gap SHALL all be received; IDLE accepts a start bit on the first edge after STOP.

Reset
REQ-025 While rst=0: state IDLE; counters 0; shift register 0; synchronizers and filtered clock 1 (bus idle).
REQ-026 While rst=0: ps2_rx_dat=8'd0, ps2_rx_stb=0, ps2_rx_err=0, dbg=0.
REQ-027 Reset asserted mid-frame SHALL abort the frame without any strobe, including after release.
REQ-028 Release of rst SHALL be synchronous to clk; the first edge is accepted no earlier than FILTER_LEN cycles after release.

Configuration
REQ-029 Macro FPGA_ROBOTS_PS2_PARITY_CHECK_EN: when defined, a frame is valid only if data plus parity has an odd number of ones. A parity failure pulses ps2_rx_err and no ps2_rx_stb.
REQ-030 When FPGA_ROBOTS_PS2_PARITY_CHECK_EN is not defined, the parity bit is clocked in but ignored; only the stop bit decides validity.

Verification
REQ-031 Frame 0x1C, parity 0, stop 1 at a 80 us bit period -> ps2_rx_dat=0x1C, exactly one ps2_rx_stb, ps2_rx_err never asserted.
REQ-032 Frame 0x1C with parity 1 -> with EN: one ps2_rx_err, no stb, ps2_rx_dat keeps its previous value; without EN: stb with 0x1C.
REQ-033 A 3-cycle low glitch on ps2_clk in IDLE (FILTER_LEN=8), then frames E0, 75 -> no stray err; stb with 0xE0, then stb with 0x75.
REQ-034 Start bit plus 4 data bits, then ps2_clk held high for TIMEOUT+10 cycles -> one ps2_rx_err, dbg=0; next frame 0xF0 -> stb with 0xF0.
REQ-035 Stop bit driven 0 on frame 0x29 -> one ps2_rx_err, no stb; rst pulsed low after data bit 5 of a later frame -> no strobe, all outputs 0, and the next full frame is received correctly.

Source files
------------

// File: rtl/fpga_robots_game_ps2_rx.sv
// PS/2 device-to-host receiver: synchronizes and de-glitches ps2_clk, then shifts in 11-bit frames.
// Optional macro FPGA_ROBOTS_PS2_PARITY_CHECK_EN rejects frames with bad odd parity.
module fpga_robots_game_ps2_rx #(
    parameter int unsigned FILTER_LEN = 8,
    parameter int unsigned TIMEOUT    = 100000
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] ps2_rx_dat,
    output logic       ps2_rx_stb,
    output logic       ps2_rx_err,
    output logic       dbg
);

    localparam int unsigned FW = $clog2(FILTER_LEN + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

`ifdef FPGA_ROBOTS_PS2_PARITY_CHECK_EN
    localparam logic PAR_CHK = 1'b1;
`else
    localparam logic PAR_CHK = 1'b0;
`endif

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    logic [1:0]    rst_sync;
    logic          rst_i;
    logic          ck_meta, ck_sync, dt_meta, dt_sync;
    logic [FW-1:0] filt_cnt;
    logic          filt, filt_d;
    logic          fall_c;

    state_t        state, state_nxt;
    logic [2:0]    bit_cnt, bit_nxt;
    logic [7:0]    shreg, shreg_nxt;
    logic          par, par_nxt;
    logic [TW-1:0] tmo, tmo_nxt;
    logic [7:0]    dat_nxt;
    logic          stb_nxt, err_nxt;
    logic          par_ok_c;

    // Asynchronous assertion, clk-synchronous release.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) rst_sync <= 2'b00;
        else      rst_sync <= {rst_sync[0], 1'b1};
    end
    assign rst_i = rst_sync[1];

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            ck_meta  <= 1'b1;
            ck_sync  <= 1'b1;
            dt_meta  <= 1'b1;
            dt_sync  <= 1'b1;
            filt_cnt <= '0;
            filt     <= 1'b1;
            filt_d   <= 1'b1;
        end else begin
            ck_meta <= ps2_clk;
            ck_sync <= ck_meta;
            dt_meta <= ps2_dat;
            dt_sync <= dt_meta;
            filt_d  <= filt;
            // Filtered clock follows only a level held for FILTER_LEN cycles.
            if (ck_sync == filt) begin
                filt_cnt <= '0;
            end else if (filt_cnt == FW'(FILTER_LEN - 1)) begin
                filt     <= ck_sync;
                filt_cnt <= '0;
            end else begin
                filt_cnt <= filt_cnt + FW'(1);
            end
        end
    end

    assign fall_c   = filt_d & ~filt;
    assign par_ok_c = ~PAR_CHK | (^{shreg, par});

    always_comb begin
        state_nxt = state;
        bit_nxt   = bit_cnt;
        shreg_nxt = shreg;
        par_nxt   = par;
        tmo_nxt   = tmo;
        dat_nxt   = ps2_rx_dat;
        stb_nxt   = 1'b0;
        err_nxt   = 1'b0;
        if (fall_c) begin
            tmo_nxt = '0;
            case (state)
                IDLE: begin
                    if (!dt_sync) begin
                        state_nxt = DATA;
                        bit_nxt   = 3'd0;
                        shreg_nxt = 8'd0;
                    end else begin
                        err_nxt = 1'b1;
                    end
                end
                DATA: begin
                    shreg_nxt[bit_cnt] = dt_sync;
                    if (bit_cnt == 3'd7) state_nxt = PARITY;
                    else                 bit_nxt   = bit_cnt + 3'd1;
                end
                PARITY: begin
                    par_nxt   = dt_sync;
                    state_nxt = STOP;
                end
                default: begin
                    if (dt_sync && par_ok_c) begin
                        dat_nxt = shreg;
                        stb_nxt = 1'b1;
                    end else begin
                        err_nxt = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            endcase
        end else if (state != IDLE) begin
            // An edge in the same cycle wins over the timeout (handled above).
            if (tmo == TW'(TIMEOUT)) begin
                state_nxt = IDLE;
                err_nxt   = 1'b1;
                tmo_nxt   = '0;
            end else begin
                tmo_nxt = tmo + TW'(1);
            end
        end else begin
            tmo_nxt = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_i) begin
        if (!rst_i) begin
            state      <= IDLE;
            bit_cnt    <= 3'd0;
            shreg      <= 8'd0;
            par        <= 1'b0;
            tmo        <= '0;
            ps2_rx_dat <= 8'd0;
            ps2_rx_stb <= 1'b0;
            ps2_rx_err <= 1'b0;
            dbg        <= 1'b0;
        end else begin
            state      <= state_nxt;
            bit_cnt    <= bit_nxt;
            shreg      <= shreg_nxt;
            par        <= par_nxt;
            tmo        <= tmo_nxt;
            ps2_rx_dat <= dat_nxt;
            ps2_rx_stb <= stb_nxt;
            ps2_rx_err <= err_nxt;
            dbg        <= (state_nxt != IDLE);
        end
    end

endmodule

// File: tb/tb_fpga_robots_game_ps2_rx.sv
// Directed bench for fpga_robots_game_ps2_rx: frames, parity, glitch, timeout, bad stop, mid-frame reset.
module tb_fpga_robots_game_ps2_rx;

    localparam int unsigned FILTER_LEN = 8;
    localparam int unsigned TIMEOUT    = 300;
    localparam int          HALF       = 30;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       ps2_clk = 1'b1;
    logic       ps2_dat = 1'b1;
    logic [7:0] ps2_rx_dat;
    logic       ps2_rx_stb;
    logic       ps2_rx_err;
    logic       dbg;

    int checks = 0;
    int errors = 0;
    int stb_cnt = 0;
    int err_cnt = 0;
    int both_cnt = 0;
    logic [7:0] cap [0:3];

    fpga_robots_game_ps2_rx #(.FILTER_LEN(FILTER_LEN), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst        (rst),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .ps2_rx_dat (ps2_rx_dat),
        .ps2_rx_stb (ps2_rx_stb),
        .ps2_rx_err (ps2_rx_err),
        .dbg        (dbg)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (ps2_rx_stb) begin
            if (stb_cnt < 4) cap[stb_cnt] = ps2_rx_dat;
            stb_cnt = stb_cnt + 1;
        end
        if (ps2_rx_err) err_cnt = err_cnt + 1;
        if (ps2_rx_stb && ps2_rx_err) both_cnt = both_cnt + 1;
    end

    function automatic logic [10:0] mk_frame(input logic [7:0] b, input logic flip, input logic stop);
        return {stop, (~^b) ^ flip, b, 1'b0};
    endfunction

    task automatic clear_counts();
        stb_cnt = 0;
        err_cnt = 0;
    endtask

    task automatic send_bits(input logic [10:0] bits, input int n);
        for (int i = 0; i < n; i++) begin
            ps2_dat = bits[i];
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b0;
            repeat (HALF) @(negedge clk);
            ps2_clk = 1'b1;
        end
        ps2_dat = 1'b1;
    endtask

    task automatic test_reset();
        repeat (5) @(negedge clk);
        checks++; if (ps2_rx_dat !== 8'h00) begin errors++; $display("FAIL reset_dat got %h want 00", ps2_rx_dat); end
        checks++; if (ps2_rx_stb !== 1'b0) begin errors++; $display("FAIL reset_stb got %b want 0", ps2_rx_stb); end
        checks++; if (ps2_rx_err !== 1'b0) begin errors++; $display("FAIL reset_err got %b want 0", ps2_rx_err); end
        checks++; if (dbg !== 1'b0) begin errors++; $display("FAIL reset_dbg got %b want 0", dbg); end
        rst = 1'b1;
        repeat (20) @(negedge clk);
    endtask

    task automatic test_frame_1c();
        clear_counts();
        send_bits(mk_frame(8'h1C, 1'b0, 1'b1), 11);
        repeat (40) @(negedge clk);
        checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL f1c_stb_count got %0d want 1", stb_cnt); end
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL f1c_err_count got %0d want 0", err_cnt); end
        checks++; if (cap[0] !== 8'h1C) begin errors++; $display("FAIL f1c_strobe_data got %h want 1c", cap[0]); end
        checks++; if (ps2_rx_dat !== 8'h1C) begin errors++; $display("FAIL f1c_held_data got %h want 1c", ps2_rx_dat); end
    endtask

    task automatic test_parity_bad();
        clear_counts();
        send_bits(mk_frame(8'h1C, 1'b1, 1'b1), 11);
        repeat (40) @(negedge clk);
`ifdef FPGA_ROBOTS_PS2_PARITY_CHECK_EN
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL par_err_count got %0d want 1", err_cnt); end
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL par_stb_count got %0d want 0", stb_cnt); end
`else
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL par_err_count got %0d want 0", err_cnt); end
        checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL par_stb_count got %0d want 1", stb_cnt); end
`endif
        checks++; if (ps2_rx_dat !== 8'h1C) begin errors++; $display("FAIL par_data got %h want 1c", ps2_rx_dat); end
    endtask

    task automatic test_glitch_back_to_back();
        clear_counts();
        ps2_clk = 1'b0;
        repeat (3) @(negedge clk);
        ps2_clk = 1'b1;
        repeat (20) @(negedge clk);
        send_bits(mk_frame(8'hE0, 1'b0, 1'b1), 11);
        send_bits(mk_frame(8'h75, 1'b0, 1'b1), 11);
        repeat (40) @(negedge clk);
        checks++; if (err_cnt !== 0) begin errors++; $display("FAIL glitch_err_count got %0d want 0", err_cnt); end
        checks++; if (stb_cnt !== 2) begin errors++; $display("FAIL b2b_stb_count got %0d want 2", stb_cnt); end
        checks++; if (cap[0] !== 8'hE0) begin errors++; $display("FAIL b2b_first got %h want e0", cap[0]); end
        checks++; if (cap[1] !== 8'h75) begin errors++; $display("FAIL b2b_second got %h want 75", cap[1]); end
    endtask

    task automatic test_timeout();
        clear_counts();
        send_bits(mk_frame(8'hA5, 1'b0, 1'b1), 5);
        checks++; if (dbg !== 1'b1) begin errors++; $display("FAIL tmo_dbg_midframe got %b want 1", dbg); end
        repeat (TIMEOUT + 10) @(negedge clk);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL tmo_err_count got %0d want 1", err_cnt); end
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL tmo_stb_count got %0d want 0", stb_cnt); end
        checks++; if (dbg !== 1'b0) begin errors++; $display("FAIL tmo_dbg_after got %b want 0", dbg); end
        checks++; if (ps2_rx_dat !== 8'h75) begin errors++; $display("FAIL tmo_data_kept got %h want 75", ps2_rx_dat); end
        clear_counts();
        send_bits(mk_frame(8'hF0, 1'b0, 1'b1), 11);
        repeat (40) @(negedge clk);
        checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL f0_stb_count got %0d want 1", stb_cnt); end
        checks++; if (cap[0] !== 8'hF0) begin errors++; $display("FAIL f0_data got %h want f0", cap[0]); end
    endtask

    task automatic test_bad_stop();
        clear_counts();
        send_bits(mk_frame(8'h29, 1'b0, 1'b0), 11);
        repeat (40) @(negedge clk);
        checks++; if (err_cnt !== 1) begin errors++; $display("FAIL stop_err_count got %0d want 1", err_cnt); end
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL stop_stb_count got %0d want 0", stb_cnt); end
    endtask

    task automatic test_reset_midframe();
        clear_counts();
        send_bits(mk_frame(8'h3C, 1'b0, 1'b1), 7);
        rst = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (ps2_rx_dat !== 8'h00) begin errors++; $display("FAIL rstmid_dat got %h want 00", ps2_rx_dat); end
        checks++; if (ps2_rx_stb !== 1'b0) begin errors++; $display("FAIL rstmid_stb got %b want 0", ps2_rx_stb); end
        checks++; if (ps2_rx_err !== 1'b0) begin errors++; $display("FAIL rstmid_err got %b want 0", ps2_rx_err); end
        checks++; if (dbg !== 1'b0) begin errors++; $display("FAIL rstmid_dbg got %b want 0", dbg); end
        rst = 1'b1;
        repeat (40) @(negedge clk);
        checks++; if (stb_cnt !== 0) begin errors++; $display("FAIL rstmid_no_stb got %0d want 0", stb_cnt); end
        send_bits(mk_frame(8'h5A, 1'b0, 1'b1), 11);
        repeat (40) @(negedge clk);
        checks++; if (stb_cnt !== 1) begin errors++; $display("FAIL rstmid_next_stb got %0d want 1", stb_cnt); end
        checks++; if (ps2_rx_dat !== 8'h5A) begin errors++; $display("FAIL rstmid_next_data got %h want 5a", ps2_rx_dat); end
    endtask

    task automatic test_exclusive();
        checks++; if (both_cnt !== 0) begin errors++; $display("FAIL stb_err_overlap got %0d want 0", both_cnt); end
    endtask

    initial begin
        for (int i = 0; i < 4; i++) cap[i] = 8'h00;
        test_reset();
        test_frame_1c();
        test_parity_bad();
        test_glitch_back_to_back();
        test_timeout();
        test_bad_stop();
        test_reset_midframe();
        test_exclusive();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
